// File: rtl/alu_pkg.sv
// Shared definitions for the pipelined ARM data-processing ALU:
// opcode encodings, flag bit positions and adder sizing.
package alu_pkg;

    localparam logic [3:0] FN_AND = 4'h0;
    localparam logic [3:0] FN_EOR = 4'h1;
    localparam logic [3:0] FN_SUB = 4'h2;
    localparam logic [3:0] FN_RSB = 4'h3;
    localparam logic [3:0] FN_ADD = 4'h4;
    localparam logic [3:0] FN_ADC = 4'h5;
    localparam logic [3:0] FN_SBC = 4'h6;
    localparam logic [3:0] FN_RSC = 4'h7;
    localparam logic [3:0] FN_TST = 4'h8;
    localparam logic [3:0] FN_TEQ = 4'h9;
    localparam logic [3:0] FN_CMP = 4'hA;
    localparam logic [3:0] FN_CMN = 4'hB;
    localparam logic [3:0] FN_ORR = 4'hC;
    localparam logic [3:0] FN_MOV = 4'hD;
    localparam logic [3:0] FN_BIC = 4'hE;
    localparam logic [3:0] FN_MVN = 4'hF;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    // Extra adder bit above the datapath that captures carry-out.
    localparam int ADDER_GUARD_BITS = 1;

    // TST/TEQ/CMP/CMN (0x8..0xB) only set flags and never write back.
    function automatic logic fn_is_compare(input logic [3:0] fn);
        return (fn[3:2] == 2'b10);
    endfunction

endpackage

// File: rtl/alu_core.sv
// Combinational ARM data-processing core: one shared adder for all arithmetic
// ops, bitwise unit for logical ops, and NZCV generation.
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [3:0]       i_fn,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_shifter_c,
    input  logic [3:0]       i_flags_in,
    output logic [WIDTH-1:0] o_r,
    output logic [3:0]       o_nzcv,
    output logic             o_wr_en
);

    logic [WIDTH-1:0]                  w_x;
    logic [WIDTH-1:0]                  w_y;
    logic                              w_cin;
    logic                              w_arith;
    logic [WIDTH-1:0]                  w_logic;
    logic [WIDTH+ADDER_GUARD_BITS-1:0] w_sum;
    logic                              w_unused_flags;

    // Operand steering: subtracts become X + ~Y + cin on the single adder.
    always_comb begin
        w_x     = '0;
        w_y     = '0;
        w_cin   = 1'b0;
        w_arith = 1'b1;
        case (i_fn)
            FN_ADD, FN_CMN: begin w_x = i_a; w_y = i_b;  w_cin = 1'b0; end
            FN_ADC:         begin w_x = i_a; w_y = i_b;  w_cin = i_flags_in[FLAG_C]; end
            FN_SUB, FN_CMP: begin w_x = i_a; w_y = ~i_b; w_cin = 1'b1; end
            FN_SBC:         begin w_x = i_a; w_y = ~i_b; w_cin = i_flags_in[FLAG_C]; end
            FN_RSB:         begin w_x = i_b; w_y = ~i_a; w_cin = 1'b1; end
            FN_RSC:         begin w_x = i_b; w_y = ~i_a; w_cin = i_flags_in[FLAG_C]; end
            default:        w_arith = 1'b0;
        endcase
    end

    always_comb begin
        w_logic = '0;
        case (i_fn)
            FN_AND, FN_TST: w_logic = i_a & i_b;
            FN_EOR, FN_TEQ: w_logic = i_a ^ i_b;
            FN_ORR:         w_logic = i_a | i_b;
            FN_MOV:         w_logic = i_b;
            FN_BIC:         w_logic = i_a & ~i_b;
            FN_MVN:         w_logic = ~i_b;
            default:        w_logic = '0;
        endcase
    end

    assign w_sum = {{ADDER_GUARD_BITS{1'b0}}, w_x}
                 + {{ADDER_GUARD_BITS{1'b0}}, w_y}
                 + {{WIDTH{1'b0}}, w_cin};

    assign o_r = w_arith ? w_sum[WIDTH-1:0] : w_logic;

    assign o_nzcv[FLAG_N] = o_r[WIDTH-1];
    assign o_nzcv[FLAG_Z] = (o_r == '0);
    assign o_nzcv[FLAG_C] = w_arith ? w_sum[WIDTH] : i_shifter_c;
    assign o_nzcv[FLAG_V] = w_arith ? ((w_x[WIDTH-1] == w_y[WIDTH-1]) && (o_r[WIDTH-1] != w_x[WIDTH-1]))
                                    : i_flags_in[FLAG_V];

    assign o_wr_en = !fn_is_compare(i_fn);

    // N and Z of the incoming flags never influence a result.
    assign w_unused_flags = ^i_flags_in[FLAG_N:FLAG_Z];

endmodule

// File: rtl/alu_pipe.sv
// Two-stage pipelined ALU (E1 operands, E2 result) with valid/ready on both
// sides and the architectural NZCV register updated on the E1->E2 edge.
module alu_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic [3:0]       i_fn,
    input  logic             i_s,
    input  logic [WIDTH-1:0] i_left_op,
    input  logic [WIDTH-1:0] i_right_op,
    input  logic             i_shifter_c,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic [WIDTH-1:0] o_alu_output,
    output logic             o_wr_en,
    output logic [3:0]       o_out_flags,
    output logic [3:0]       o_flags
);

    logic             r_e1_valid;
    logic [3:0]       r_e1_fn;
    logic             r_e1_s;
    logic [WIDTH-1:0] r_e1_a;
    logic [WIDTH-1:0] r_e1_b;
    logic             r_e1_shifter_c;

    logic             r_e2_valid;
    logic [WIDTH-1:0] r_e2_result;
    logic [3:0]       r_e2_flags;
    logic             r_e2_wr_en;

    logic [3:0]       r_flags;

    logic             w_advance_e2;
    logic [WIDTH-1:0] w_core_r;
    logic [3:0]       w_core_nzcv;
    logic             w_core_wr_en;

    alu_core #(.WIDTH(WIDTH)) u_core (
        .i_fn        (r_e1_fn),
        .i_a         (r_e1_a),
        .i_b         (r_e1_b),
        .i_shifter_c (r_e1_shifter_c),
        .i_flags_in  (r_flags),
        .o_r         (w_core_r),
        .o_nzcv      (w_core_nzcv),
        .o_wr_en     (w_core_wr_en)
    );

    assign w_advance_e2 = !r_e2_valid || i_out_ready;
    assign o_in_ready   = !r_e1_valid || w_advance_e2;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_e1_valid     <= 1'b0;
            r_e1_fn        <= '0;
            r_e1_s         <= 1'b0;
            r_e1_a         <= '0;
            r_e1_b         <= '0;
            r_e1_shifter_c <= 1'b0;
        end else if (o_in_ready) begin
            r_e1_valid <= i_in_valid;
            if (i_in_valid) begin
                r_e1_fn        <= i_fn;
                r_e1_s         <= i_s;
                r_e1_a         <= i_left_op;
                r_e1_b         <= i_right_op;
                r_e1_shifter_c <= i_shifter_c;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_e2_valid  <= 1'b0;
            r_e2_result <= '0;
            r_e2_flags  <= '0;
            r_e2_wr_en  <= 1'b0;
        end else if (w_advance_e2) begin
            r_e2_valid <= r_e1_valid;
            if (r_e1_valid) begin
                r_e2_result <= w_core_r;
                r_e2_flags  <= w_core_nzcv;
                r_e2_wr_en  <= w_core_wr_en;
            end
        end
    end

    // Committing flags as the op leaves E1 means the next op in E1 already
    // sees them, so no forwarding path is required.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_flags <= '0;
        end else if (w_advance_e2 && r_e1_valid && r_e1_s) begin
            r_flags <= w_core_nzcv;
        end
    end

    assign o_out_valid  = r_e2_valid;
    assign o_alu_output = r_e2_result;
    assign o_wr_en      = r_e2_wr_en;
    assign o_out_flags  = r_e2_flags;
    assign o_flags      = r_flags;

endmodule
